// File: rtl/rr_grant_arbiter8.sv
// rr_grant_arbiter8
// Round-robin arbiter sharing one resource among 8 requesters.
// Registered one-hot grant plus binary owner index. A grant is held while
// its owner keeps requesting, optionally bounded to MAX_HOLD cycles
// (MAX_HOLD = 0 means unlimited). One idle cycle always separates grants.
//
// Optional build macro ARB_GRANT_COUNT_EN adds a 16-bit wrapping grant
// counter (output grant_count) with a synchronous clear (input count_clr).
module rr_grant_arbiter8 #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_vld,
  output logic       expired
`ifdef ARB_GRANT_COUNT_EN
  ,
  input  logic        count_clr,
  output logic [15:0] grant_count
`endif
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  // Hold counter value seen on the edge where the grant has been visible
  // MAX_HOLD cycles; only meaningful when the hold limit is enabled.
  localparam logic [CNT_W-1:0] HOLD_LAST    = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);
  localparam bit               HOLD_LIMITED = (MAX_HOLD != 0);

  // Returns {found, index}: first set request bit scanning ptr, ptr+1, ...
  // ptr+7 modulo 8. The downward loop lets the lowest offset win.
  function automatic logic [3:0] rr_pick(input logic [7:0] req_i, input logic [2:0] ptr_i);
    logic [3:0] res;
    logic [2:0] idx;
    res = '0;
    for (int k = 7; k >= 0; k--) begin
      idx = ptr_i + 3'(k);
      if (req_i[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  state_t           r_state;
  logic [2:0]       r_ptr;
  logic [CNT_W-1:0] r_hold_cnt;
  logic [7:0]       r_gnt;
  logic [2:0]       r_gnt_idx;
  logic             r_gnt_vld;
  logic             r_expired;

  state_t           w_state_nxt;
  logic [2:0]       w_ptr_nxt;
  logic [CNT_W-1:0] w_hold_nxt;
  logic [7:0]       w_gnt_nxt;
  logic [2:0]       w_idx_nxt;
  logic             w_vld_nxt;
  logic             w_exp_nxt;

  logic [3:0]       w_pick;
  logic             w_pick_vld;
  logic [2:0]       w_pick_idx;
  logic             w_owner_req;
  logic             w_hold_hit;

  assign w_pick      = rr_pick(req, r_ptr);
  assign w_pick_vld  = w_pick[3];
  assign w_pick_idx  = w_pick[2:0];
  assign w_owner_req = req[r_gnt_idx];
  assign w_hold_hit  = HOLD_LIMITED && (r_hold_cnt == HOLD_LAST);

  // Next-state and next-output decode for the IDLE/GRANT machine.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_hold_nxt  = r_hold_cnt;
    w_gnt_nxt   = r_gnt;
    w_idx_nxt   = r_gnt_idx;
    w_vld_nxt   = r_gnt_vld;
    w_exp_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (en && w_pick_vld) begin
          w_state_nxt = S_GRANT;
          w_gnt_nxt   = 8'd1 << w_pick_idx;
          w_idx_nxt   = w_pick_idx;
          w_vld_nxt   = 1'b1;
          // Move past the new owner so it becomes lowest priority next time.
          w_ptr_nxt   = w_pick_idx + 3'd1;
          w_hold_nxt  = '0;
        end
      end
      S_GRANT: begin
        if (r_hold_cnt != {CNT_W{1'b1}}) w_hold_nxt = r_hold_cnt + 1'b1;
        if (!w_owner_req || !en) begin
          // Owner drop or disable takes precedence over a timeout on the
          // same edge, so expired stays low in that case.
          w_state_nxt = S_IDLE;
          w_gnt_nxt   = '0;
          w_vld_nxt   = 1'b0;
        end else if (w_hold_hit) begin
          w_state_nxt = S_IDLE;
          w_gnt_nxt   = '0;
          w_vld_nxt   = 1'b0;
          w_exp_nxt   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_gnt_nxt   = '0;
        w_vld_nxt   = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset clears a live grant without a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_hold_cnt <= '0;
      r_gnt      <= '0;
      r_gnt_idx  <= '0;
      r_gnt_vld  <= 1'b0;
      r_expired  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_gnt      <= w_gnt_nxt;
      r_gnt_idx  <= w_idx_nxt;
      r_gnt_vld  <= w_vld_nxt;
      r_expired  <= w_exp_nxt;
    end
  end

  assign gnt     = r_gnt;
  assign gnt_idx = r_gnt_idx;
  assign gnt_vld = r_gnt_vld;
  assign expired = r_expired;

`ifdef ARB_GRANT_COUNT_EN
  logic [15:0] r_grant_count;
  logic        w_start;

  assign w_start = (r_state == S_IDLE) && (w_state_nxt == S_GRANT);

  // Counts IDLE->GRANT transitions; clear wins over increment, wraps at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant_count <= '0;
    end else if (count_clr) begin
      r_grant_count <= '0;
    end else if (w_start) begin
      r_grant_count <= r_grant_count + 16'd1;
    end
  end

  assign grant_count = r_grant_count;
`endif

endmodule
